dpram_initiator: RTL and testbench

- Requester-side front end for the 16x8 dual-port RAM (DualBoot).
- Accepts read/write commands on two independent valid/ready channels, A and B, and drives the RAM's add/datain/en pins for each port.
- Captures read data after the RAM read latency and returns it on per-port response channels.
- Resolves same-address cross-port hazards deterministically, so that RAM behaviour under collisions is never undefined.

---
 rtl/dpram_initiator_pkg.sv | 37 +++
 rtl/dpram_initiator_port_fsm.sv | 110 +++++++++++
 rtl/dpram_initiator.sv | 113 +++++++++++
 tb/tb_dpram_initiator.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_initiator_pkg.sv
// Shared types and helpers for the dual-port RAM initiator: port FSM states,
// latency counter sizing and the same-address hazard resolver.
package dpram_init_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RD  = 2'd1,
        HOLD_RSP = 2'd2
    } port_state_e;

    // Wide enough to hold the largest supported read latency (4).
    localparam int LAT_CNT_W = $clog2(4) + 1;

    // Addresses are zero-extended to this width before hazard comparison.
    localparam int MAX_ADDR_W = 16;

    // Returns {stall_a, stall_b}. A write always wins over the other port so that
    // write/write leaves B's data last and a cross-port read sees the new data.
    function automatic logic [1:0] same_addr_hazard(
        input logic                  we_a,
        input logic                  we_b,
        input logic [MAX_ADDR_W-1:0] addr_a,
        input logic [MAX_ADDR_W-1:0] addr_b
    );
        logic [1:0] stall;
        stall = 2'b00;
        if (addr_a == addr_b) begin
            if (we_a) begin
                stall = 2'b01;
            end else if (we_b) begin
                stall = 2'b10;
            end
        end
        return stall;
    endfunction

endpackage

// File: rtl/dpram_initiator_port_fsm.sv
// One requester port: command acceptance, registered RAM pins, read latency
// tracking and a held response register (one outstanding read at a time).
module dpram_port_fsm
    import dpram_init_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_datain,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              idle
);

    port_state_e          state_q;
    port_state_e          state_d;
    logic [LAT_CNT_W-1:0] cnt_q;
    logic [LAT_CNT_W-1:0] cnt_d;
    logic                 run_q;
    logic                 accept;
    logic                 capture;

    // run_q keeps cmd_ready low while reset is asserted and for the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
        end
    end

    assign idle      = run_q && (state_q == IDLE);
    assign cmd_ready = idle && !stall;
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (state_q == HOLD_RSP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !cmd_we) begin
                    state_d = WAIT_RD;
                    cnt_d   = LAT_CNT_W'(RD_LAT);
                end
            end
            WAIT_RD: begin
                // Data is valid on the RAM output once RD_LAT edges have passed since the address went out.
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = HOLD_RSP;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            HOLD_RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM pins are registered; the address holds its last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_add    <= '0;
            ram_datain <= '0;
            ram_en     <= 1'b0;
        end else begin
            ram_en <= accept && cmd_we;
            if (accept) begin
                ram_add <= cmd_addr;
            end
            if (accept && cmd_we) begin
                ram_datain <= cmd_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
        end else if (capture) begin
            rsp_rdata <= ram_data_out;
        end
    end

endmodule

// File: rtl/dpram_initiator.sv
// Requester front end for the 16x8 dual-port RAM: two command/response channels
// with deterministic same-address hazard resolution and a collision counter.
module dpram_initiator
    import dpram_init_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_a,
    input  logic              cmd_valid_b,
    output logic              cmd_ready_a,
    output logic              cmd_ready_b,
    input  logic              cmd_we_a,
    input  logic              cmd_we_b,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_wdata_a,
    input  logic [DATA_W-1:0] cmd_wdata_b,
    output logic              rsp_valid_a,
    output logic              rsp_valid_b,
    input  logic              rsp_ready_a,
    input  logic              rsp_ready_b,
    output logic [DATA_W-1:0] rsp_rdata_a,
    output logic [DATA_W-1:0] rsp_rdata_b,
    output logic [ADDR_W-1:0] ram_add_a,
    output logic [ADDR_W-1:0] ram_add_b,
    output logic [DATA_W-1:0] ram_datain_a,
    output logic [DATA_W-1:0] ram_datain_b,
    output logic              ram_en_a,
    output logic              ram_en_b,
    input  logic [DATA_W-1:0] ram_data_out_a,
    input  logic [DATA_W-1:0] ram_data_out_b,
    output logic [CNT_W-1:0]  collision_cnt
);

    logic       idle_a;
    logic       idle_b;
    logic       contend;
    logic [1:0] hazard;
    logic       stall_a;
    logic       stall_b;
    logic       blocked;

    // Hazards only matter when both ports could be accepted on the same edge.
    assign contend = idle_a && idle_b && cmd_valid_a && cmd_valid_b;
    assign hazard  = contend ? same_addr_hazard(cmd_we_a, cmd_we_b,
                                                MAX_ADDR_W'(cmd_addr_a),
                                                MAX_ADDR_W'(cmd_addr_b))
                             : 2'b00;
    assign stall_a = hazard[1];
    assign stall_b = hazard[0];
    assign blocked = (stall_a && cmd_valid_a) || (stall_b && cmd_valid_b);

    dpram_port_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_port_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall_a),
        .cmd_valid    (cmd_valid_a),
        .cmd_ready    (cmd_ready_a),
        .cmd_we       (cmd_we_a),
        .cmd_addr     (cmd_addr_a),
        .cmd_wdata    (cmd_wdata_a),
        .rsp_valid    (rsp_valid_a),
        .rsp_ready    (rsp_ready_a),
        .rsp_rdata    (rsp_rdata_a),
        .ram_add      (ram_add_a),
        .ram_datain   (ram_datain_a),
        .ram_en       (ram_en_a),
        .ram_data_out (ram_data_out_a),
        .idle         (idle_a)
    );

    dpram_port_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_port_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall_b),
        .cmd_valid    (cmd_valid_b),
        .cmd_ready    (cmd_ready_b),
        .cmd_we       (cmd_we_b),
        .cmd_addr     (cmd_addr_b),
        .cmd_wdata    (cmd_wdata_b),
        .rsp_valid    (rsp_valid_b),
        .rsp_ready    (rsp_ready_b),
        .rsp_rdata    (rsp_rdata_b),
        .ram_add      (ram_add_b),
        .ram_datain   (ram_datain_b),
        .ram_en       (ram_en_b),
        .ram_data_out (ram_data_out_b),
        .idle         (idle_b)
    );

    // Saturating count of cycles in which a valid command was held off by a hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_cnt <= '0;
        end else if (blocked && (collision_cnt != '1)) begin
            collision_cnt <= collision_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dpram_initiator.sv
// Randomised scoreboard bench for dpram_initiator with a behavioural RAM and a
// transaction-level reference model of acceptance, hazards and response timing.
module tb_dpram_initiator;

    localparam int RD_LAT = 1;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid_a, cmd_valid_b;
    logic       cmd_ready_a, cmd_ready_b;
    logic       cmd_we_a, cmd_we_b;
    logic [3:0] cmd_addr_a, cmd_addr_b;
    logic [7:0] cmd_wdata_a, cmd_wdata_b;
    logic       rsp_valid_a, rsp_valid_b;
    logic       rsp_ready_a, rsp_ready_b;
    logic [7:0] rsp_rdata_a, rsp_rdata_b;
    logic [3:0] ram_add_a, ram_add_b;
    logic [7:0] ram_datain_a, ram_datain_b;
    logic       ram_en_a, ram_en_b;
    logic [7:0] ram_data_out_a, ram_data_out_b;
    logic [7:0] collision_cnt;

    int vectors;
    int miscompares;

    dpram_initiator #(
        .ADDR_W (4),
        .DATA_W (8),
        .RD_LAT (RD_LAT),
        .CNT_W  (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid_a    (cmd_valid_a),
        .cmd_valid_b    (cmd_valid_b),
        .cmd_ready_a    (cmd_ready_a),
        .cmd_ready_b    (cmd_ready_b),
        .cmd_we_a       (cmd_we_a),
        .cmd_we_b       (cmd_we_b),
        .cmd_addr_a     (cmd_addr_a),
        .cmd_addr_b     (cmd_addr_b),
        .cmd_wdata_a    (cmd_wdata_a),
        .cmd_wdata_b    (cmd_wdata_b),
        .rsp_valid_a    (rsp_valid_a),
        .rsp_valid_b    (rsp_valid_b),
        .rsp_ready_a    (rsp_ready_a),
        .rsp_ready_b    (rsp_ready_b),
        .rsp_rdata_a    (rsp_rdata_a),
        .rsp_rdata_b    (rsp_rdata_b),
        .ram_add_a      (ram_add_a),
        .ram_add_b      (ram_add_b),
        .ram_datain_a   (ram_datain_a),
        .ram_datain_b   (ram_datain_b),
        .ram_en_a       (ram_en_a),
        .ram_en_b       (ram_en_b),
        .ram_data_out_a (ram_data_out_a),
        .ram_data_out_b (ram_data_out_b),
        .collision_cnt  (collision_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16x8 dual-port RAM with RD_LAT-edge read pipeline.
    logic [7:0] ram_mem [16];
    logic [7:0] pipe_a [RD_LAT];
    logic [7:0] pipe_b [RD_LAT];

    always @(posedge clk) begin
        if (ram_en_a) ram_mem[ram_add_a] <= ram_datain_a;
        if (ram_en_b) ram_mem[ram_add_b] <= ram_datain_b;
        pipe_a[0] <= ram_mem[ram_add_a];
        pipe_b[0] <= ram_mem[ram_add_b];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end

    assign ram_data_out_a = pipe_a[RD_LAT-1];
    assign ram_data_out_b = pipe_b[RD_LAT-1];

    // Reference model: memory image, per-port busy/timer, expected read data queues.
    logic [7:0] ref_mem [16];
    logic [7:0] exp_q_a [$];
    logic [7:0] exp_q_b [$];
    bit  busy_a, busy_b;
    int  timer_a, timer_b;
    int  col_model;
    bit  acc_rd_a, acc_rd_b, took_a, took_b, col_evt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic noteFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got response, expected none at %0t", name, $time);
    endtask

    task automatic resetModel();
        busy_a = 0; busy_b = 0;
        timer_a = 0; timer_b = 0;
        col_model = 0;
        acc_rd_a = 0; acc_rd_b = 0;
        took_a = 0; took_b = 0;
        col_evt = 0;
        exp_q_a.delete();
        exp_q_b.delete();
    endtask

    // One cycle: apply last cycle's decisions at the edge, drive, check, decide.
    task automatic applyStimulus(
        input logic va, input logic wa, input logic [3:0] aa, input logic [7:0] da, input logic ra,
        input logic vb, input logic wb, input logic [3:0] ab, input logic [7:0] db, input logic rb
    );
        bit exp_valid_a, exp_valid_b, exp_ready_a, exp_ready_b;
        bit contend, blk_a, blk_b, acc_a, acc_b;
        @(posedge clk);
        if (busy_a) begin
            if (timer_a == 0) begin
                if (took_a) busy_a = 0;
            end else begin
                timer_a--;
            end
        end
        if (busy_b) begin
            if (timer_b == 0) begin
                if (took_b) busy_b = 0;
            end else begin
                timer_b--;
            end
        end
        if (acc_rd_a) begin busy_a = 1; timer_a = RD_LAT + 1; end
        if (acc_rd_b) begin busy_b = 1; timer_b = RD_LAT + 1; end
        if (col_evt && col_model < 255) col_model++;
        #1;
        cmd_valid_a = va; cmd_we_a = wa; cmd_addr_a = aa; cmd_wdata_a = da; rsp_ready_a = ra;
        cmd_valid_b = vb; cmd_we_b = wb; cmd_addr_b = ab; cmd_wdata_b = db; rsp_ready_b = rb;
        #1;
        exp_valid_a = busy_a && (timer_a == 0);
        exp_valid_b = busy_b && (timer_b == 0);
        contend = !busy_a && !busy_b && va && vb && (aa == ab);
        blk_b = contend && wa;
        blk_a = contend && !wa && wb;
        exp_ready_a = !busy_a && !blk_a;
        exp_ready_b = !busy_b && !blk_b;
        checkOutput("cmd_ready_a", 32'(cmd_ready_a), 32'(exp_ready_a));
        checkOutput("cmd_ready_b", 32'(cmd_ready_b), 32'(exp_ready_b));
        checkOutput("rsp_valid_a", 32'(rsp_valid_a), 32'(exp_valid_a));
        checkOutput("rsp_valid_b", 32'(rsp_valid_b), 32'(exp_valid_b));
        checkOutput("collision_cnt", 32'(collision_cnt), 32'(col_model));
        acc_a = va && exp_ready_a;
        acc_b = vb && exp_ready_b;
        acc_rd_a = acc_a && !wa;
        acc_rd_b = acc_b && !wb;
        if (acc_rd_a) exp_q_a.push_back(ref_mem[aa]);
        if (acc_rd_b) exp_q_b.push_back(ref_mem[ab]);
        if (acc_a && wa) ref_mem[aa] = da;
        if (acc_b && wb) ref_mem[ab] = db;
        took_a = exp_valid_a && ra;
        took_b = exp_valid_b && rb;
        col_evt = (va && blk_a) || (vb && blk_b);
    endtask

    task automatic idleCycles(input int n, input logic ra, input logic rb);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 4'd0, 8'd0, ra, 0, 0, 4'd0, 8'd0, rb);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cmd_ready_a"}, 32'(cmd_ready_a), 0);
        checkOutput({tag, "_cmd_ready_b"}, 32'(cmd_ready_b), 0);
        checkOutput({tag, "_rsp_valid_a"}, 32'(rsp_valid_a), 0);
        checkOutput({tag, "_rsp_valid_b"}, 32'(rsp_valid_b), 0);
        checkOutput({tag, "_rsp_rdata_a"}, 32'(rsp_rdata_a), 0);
        checkOutput({tag, "_ram_en_a"}, 32'(ram_en_a), 0);
        checkOutput({tag, "_ram_en_b"}, 32'(ram_en_b), 0);
        checkOutput({tag, "_ram_add_a"}, 32'(ram_add_a), 0);
        checkOutput({tag, "_ram_add_b"}, 32'(ram_add_b), 0);
        checkOutput({tag, "_ram_datain_a"}, 32'(ram_datain_a), 0);
        checkOutput({tag, "_collision_cnt"}, 32'(collision_cnt), 0);
    endtask

    // Monitor: every presented response must match the oldest expected read.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid_a) begin
                if (exp_q_a.size() == 0) begin
                    noteFail("rsp_spurious_a");
                end else begin
                    checkOutput("rsp_rdata_a", 32'(rsp_rdata_a), 32'(exp_q_a[0]));
                    if (rsp_ready_a) void'(exp_q_a.pop_front());
                end
            end
            if (rsp_valid_b) begin
                if (exp_q_b.size() == 0) begin
                    noteFail("rsp_spurious_b");
                end else begin
                    checkOutput("rsp_rdata_b", 32'(rsp_rdata_b), 32'(exp_q_b[0]));
                    if (rsp_ready_b) void'(exp_q_b.pop_front());
                end
            end
        end
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        for (int i = 0; i < RD_LAT; i++) begin
            pipe_a[i] = 8'h00;
            pipe_b[i] = 8'h00;
        end
        rst_n = 1'b0;
        cmd_valid_a = 0; cmd_we_a = 0; cmd_addr_a = 0; cmd_wdata_a = 0; rsp_ready_a = 0;
        cmd_valid_b = 0; cmd_we_b = 0; cmd_addr_b = 0; cmd_wdata_b = 0; rsp_ready_b = 0;
        resetModel();
        #12;
        checkAllZero("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] idle after reset");
        idleCycles(2, 1, 1);
        checkOutput("idle_ram_en_a", 32'(ram_en_a), 0);
        checkOutput("idle_ram_en_b", 32'(ram_en_b), 0);

        $display("[TB] parallel writes and reads, different addresses");
        applyStimulus(1, 1, 4'd2, 8'd21, 1, 1, 1, 4'd3, 8'd34, 1);
        applyStimulus(1, 0, 4'd2, 8'd0, 1, 1, 0, 4'd3, 8'd0, 1);
        idleCycles(4, 1, 1);

        $display("[TB] write/write same address");
        applyStimulus(1, 1, 4'd5, 8'hAA, 1, 1, 1, 4'd5, 8'hBB, 1);
        applyStimulus(0, 0, 4'd0, 8'h00, 1, 1, 1, 4'd5, 8'hBB, 1);
        applyStimulus(1, 0, 4'd5, 8'h00, 1, 0, 0, 4'd0, 8'h00, 1);
        idleCycles(4, 1, 1);
        applyStimulus(0, 0, 4'd0, 8'h00, 1, 1, 0, 4'd5, 8'h00, 1);
        idleCycles(4, 1, 1);

        $display("[TB] write A / read B same address");
        applyStimulus(1, 1, 4'd9, 8'd99, 1, 1, 0, 4'd9, 8'h00, 1);
        applyStimulus(0, 0, 4'd0, 8'h00, 1, 1, 0, 4'd9, 8'h00, 1);
        idleCycles(4, 1, 1);

        $display("[TB] held response on A");
        applyStimulus(1, 1, 4'd10, 8'h5C, 0, 0, 0, 4'd0, 8'h00, 1);
        applyStimulus(1, 0, 4'd10, 8'h00, 0, 0, 0, 4'd0, 8'h00, 1);
        idleCycles(RD_LAT + 6, 0, 1);
        applyStimulus(1, 0, 4'd10, 8'h00, 1, 0, 0, 4'd0, 8'h00, 1);
        idleCycles(4, 1, 1);

        $display("[TB] reset during outstanding read");
        applyStimulus(1, 0, 4'd2, 8'h00, 1, 0, 0, 4'd0, 8'h00, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checkAllZero("midreset");
        resetModel();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midreset_rsp_valid_a", 32'(rsp_valid_a), 0);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        idleCycles(RD_LAT + 3, 1, 1);
        applyStimulus(1, 0, 4'd3, 8'h00, 1, 1, 0, 4'd2, 8'h00, 1);
        idleCycles(4, 1, 1);

        $display("[TB] randomised traffic");
        for (int n = 0; n < 1500; n++) begin
            applyStimulus(
                1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        idleCycles(RD_LAT + 6, 1, 1);
        checkOutput("pending_a", 32'(exp_q_a.size()), 0);
        checkOutput("pending_b", 32'(exp_q_b.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
